// File: rtl/cpu_pkg.sv
// Shared CPU constants: ARM condition-field encodings and NZCV flag bit positions.
package cpu_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Same ordering as the ALU flag vector {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator: (Cond, NZCV) -> pass.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       pass
);

  logic n_flag;
  logic z_flag;
  logic c_flag;
  logic v_flag;
  logic ge;

  assign n_flag = Flags[FLAG_N];
  assign z_flag = Flags[FLAG_Z];
  assign c_flag = Flags[FLAG_C];
  assign v_flag = Flags[FLAG_V];
  assign ge     = (n_flag == v_flag);

  always_comb begin
    pass = 1'b0;
    unique case (Cond)
      COND_EQ: pass = z_flag;
      COND_NE: pass = ~z_flag;
      COND_CS: pass = c_flag;
      COND_CC: pass = ~c_flag;
      COND_MI: pass = n_flag;
      COND_PL: pass = ~n_flag;
      COND_VS: pass = v_flag;
      COND_VC: pass = ~v_flag;
      COND_HI: pass = c_flag & ~z_flag;
      COND_LS: pass = ~c_flag | z_flag;
      COND_GE: pass = ge;
      COND_LT: pass = ~ge;
      COND_GT: pass = ~z_flag & ge;
      COND_LE: pass = z_flag | ~ge;
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution stage: NZCV flag register, write-strobe gating and a
// saturating count of squashed instructions.
module cond_unit
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  input  logic             Stall,
  input  logic             CntClr,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] SquashCnt
);

  logic [1:0]       nz_q, nz_d;
  logic [1:0]       cv_q, cv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cond_pass;
  logic             squash;

  assign Flags = {nz_q, cv_q};

  // Evaluated against registered flags only, so a flag-setting instruction
  // sees the pre-update state.
  cond_check u_cond_check (
    .Cond  (Cond),
    .Flags (Flags),
    .pass  (cond_pass)
  );

  assign CondEx   = cond_pass & ~Stall;
  assign PCSrc    = PCS & CondEx;
  assign RegWrite = RegW & CondEx & ~NoWrite;
  assign MemWrite = MemW & CondEx;
  assign squash   = ~Stall & ~cond_pass;

  always_comb begin
    nz_d = nz_q;
    cv_d = cv_q;
    if (CondEx && FlagW[1]) nz_d = ALUFlags[FLAG_N:FLAG_Z];
    if (CondEx && FlagW[0]) cv_d = ALUFlags[FLAG_C:FLAG_V];
  end

  // Clear has priority over increment; count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (CntClr)
      cnt_d = '0;
    else if (squash && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      nz_q  <= 2'b00;
      cv_q  <= 2'b00;
      cnt_q <= '0;
    end else begin
      nz_q  <= nz_d;
      cv_q  <= cv_d;
      cnt_q <= cnt_d;
    end
  end

  assign SquashCnt = cnt_q;

endmodule
